// File: rtl/rv_dbg_pkg.sv
// Shared definitions for the register-file debug dump path.
//   XLEN       : register data width
//   REG_ADDR_W : register index width
//   IDX_W      : internal index width (one extra bit so index+1 at 31 does not wrap)
//   dump_state_t : dump engine states
package rv_dbg_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned IDX_W      = REG_ADDR_W + 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    SEND_A = 3'd2,
    SEND_B = 3'd3,
    DONE   = 3'd4
  } dump_state_t;

endpackage

// File: rtl/reg_dump_reader.sv
// Debug read-out engine: claims the register-file read ports via rf_req/rf_gnt,
// reads two registers per FETCH and streams them as valid/ready beats.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   start, abort        : begin a dump when idle / return to idle from anywhere
//   rf_req, rf_gnt      : read-port ownership handshake with the core
//   rf_rs1, rf_rs2      : read addresses (non-zero only in FETCH)
//   rf_rd1, rf_rd2      : combinational read data
//   out_valid/out_ready : output beat handshake
//   out_data, out_idx   : register value and its index
//   out_last            : beat carries LAST_REG
//   busy, done          : not idle / one-cycle completion pulse
module reg_dump_reader
  import rv_dbg_pkg::*;
#(
  parameter int unsigned FIRST_REG = 0,
  parameter int unsigned LAST_REG  = 31
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  output logic                  rf_req,
  input  logic                  rf_gnt,
  output logic [REG_ADDR_W-1:0] rf_rs1,
  output logic [REG_ADDR_W-1:0] rf_rs2,
  input  logic [XLEN-1:0]       rf_rd1,
  input  logic [XLEN-1:0]       rf_rd2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_data,
  output logic [REG_ADDR_W-1:0] out_idx,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(FIRST_REG);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(LAST_REG);

  dump_state_t state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [XLEN-1:0]  buf_a_q, buf_a_d;
  logic [XLEN-1:0]  buf_b_q, buf_b_d;

  logic                  rf_req_q, rf_req_d;
  logic [REG_ADDR_W-1:0] rf_rs1_q, rf_rs1_d;
  logic [REG_ADDR_W-1:0] rf_rs2_q, rf_rs2_d;
  logic                  out_valid_q, out_valid_d;
  logic [XLEN-1:0]       out_data_q, out_data_d;
  logic [REG_ADDR_W-1:0] out_idx_q, out_idx_d;
  logic                  out_last_q, out_last_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic             accept_c;
  logic [IDX_W-1:0] idx_p1_c;
  logic [IDX_W-1:0] idx_d_p1_c;

  assign accept_c   = out_valid_q & out_ready;
  assign idx_p1_c   = idx_q + IDX_W'(1);
  assign idx_d_p1_c = idx_d + IDX_W'(1);

  // State, index and capture registers plus registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= FIRST_IDX;
      buf_a_q     <= '0;
      buf_b_q     <= '0;
      rf_req_q    <= 1'b0;
      rf_rs1_q    <= '0;
      rf_rs2_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      buf_a_q     <= buf_a_d;
      buf_b_q     <= buf_b_d;
      rf_req_q    <= rf_req_d;
      rf_rs1_q    <= rf_rs1_d;
      rf_rs2_q    <= rf_rs2_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Next state, datapath, and output values decoded from the next state so
  // that every output lines up with the state it belongs to.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    buf_a_d     = buf_a_q;
    buf_b_d     = buf_b_q;
    rf_req_d    = 1'b0;
    rf_rs1_d    = '0;
    rf_rs2_d    = '0;
    out_valid_d = 1'b0;
    out_data_d  = '0;
    out_idx_d   = '0;
    out_last_d  = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          idx_d   = FIRST_IDX;
        end
      end
      FETCH: begin
        if (rf_gnt) begin
          buf_a_d = rf_rd1;
          buf_b_d = rf_rd2;
          state_d = SEND_A;
        end
      end
      SEND_A: begin
        if (accept_c) begin
          state_d = (idx_q == LAST_IDX) ? DONE : SEND_B;
        end
      end
      SEND_B: begin
        if (accept_c) begin
          if (idx_p1_c == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(2);
            state_d = FETCH;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        idx_d   = FIRST_IDX;
      end
      default: begin
        state_d = IDLE;
        idx_d   = FIRST_IDX;
      end
    endcase

    // Abort beats everything, including a simultaneous start.
    if (abort) begin
      state_d = IDLE;
      idx_d   = FIRST_IDX;
    end

    case (state_d)
      FETCH: begin
        rf_req_d = 1'b1;
        busy_d   = 1'b1;
        rf_rs1_d = REG_ADDR_W'(idx_d);
        // Last register of an odd-sized range: both ports read the same index.
        rf_rs2_d = (idx_d == LAST_IDX) ? REG_ADDR_W'(idx_d) : REG_ADDR_W'(idx_d_p1_c);
      end
      SEND_A: begin
        rf_req_d    = 1'b1;
        busy_d      = 1'b1;
        out_valid_d = 1'b1;
        out_data_d  = buf_a_d;
        out_idx_d   = REG_ADDR_W'(idx_d);
        out_last_d  = (idx_d == LAST_IDX);
      end
      SEND_B: begin
        rf_req_d    = 1'b1;
        busy_d      = 1'b1;
        out_valid_d = 1'b1;
        out_data_d  = buf_b_d;
        out_idx_d   = REG_ADDR_W'(idx_d_p1_c);
        out_last_d  = (idx_d_p1_c == LAST_IDX);
      end
      DONE: begin
        busy_d = 1'b1;
        done_d = 1'b1;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  assign rf_req    = rf_req_q;
  assign rf_rs1    = rf_rs1_q;
  assign rf_rs2    = rf_rs2_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Bench for reg_dump_reader: a full-range instance (0..31) and a short-range
// instance (5..7) share one register-file model; a selector routes the
// active instance's outputs to the checker. The reference model is simply the
// ordered list of indices FIRST..LAST with the register contents.
module tb_reg_dump_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, abort, gnt, out_ready, sel;
  logic [31:0] rf_mem [32];

  // Full-range instance signals
  logic        start_a, req_a, valid_a, last_a, busy_a, done_a;
  logic [4:0]  rs1_a, rs2_a, idx_a;
  logic [31:0] rd1_a, rd2_a, data_a;
  // Short-range instance signals
  logic        start_b, req_b, valid_b, last_b, busy_b, done_b;
  logic [4:0]  rs1_b, rs2_b, idx_b;
  logic [31:0] rd1_b, rd2_b, data_b;

  assign start_a = start & ~sel;
  assign start_b = start & sel;
  assign rd1_a = rf_mem[rs1_a];
  assign rd2_a = rf_mem[rs2_a];
  assign rd1_b = rf_mem[rs1_b];
  assign rd2_b = rf_mem[rs2_b];

  reg_dump_reader #(.FIRST_REG(0), .LAST_REG(31)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort),
    .rf_req(req_a), .rf_gnt(gnt), .rf_rs1(rs1_a), .rf_rs2(rs2_a),
    .rf_rd1(rd1_a), .rf_rd2(rd2_a), .out_valid(valid_a), .out_ready(out_ready),
    .out_data(data_a), .out_idx(idx_a), .out_last(last_a), .busy(busy_a), .done(done_a)
  );

  reg_dump_reader #(.FIRST_REG(5), .LAST_REG(7)) u_dut_short (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort),
    .rf_req(req_b), .rf_gnt(gnt), .rf_rs1(rs1_b), .rf_rs2(rs2_b),
    .rf_rd1(rd1_b), .rf_rd2(rd2_b), .out_valid(valid_b), .out_ready(out_ready),
    .out_data(data_b), .out_idx(idx_b), .out_last(last_b), .busy(busy_b), .done(done_b)
  );

  logic        o_req, o_valid, o_last, o_busy, o_done;
  logic [4:0]  o_rs1, o_rs2, o_idx;
  logic [31:0] o_data;
  assign o_req   = sel ? req_b   : req_a;
  assign o_valid = sel ? valid_b : valid_a;
  assign o_last  = sel ? last_b  : last_a;
  assign o_busy  = sel ? busy_b  : busy_a;
  assign o_done  = sel ? done_b  : done_a;
  assign o_rs1   = sel ? rs1_b   : rs1_a;
  assign o_rs2   = sel ? rs2_b   : rs2_a;
  assign o_idx   = sel ? idx_b   : idx_a;
  assign o_data  = sel ? data_b  : data_a;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 32'(o_valid), 32'd0);
    chk({tag, "_req"},   32'(o_req),   32'd0);
    chk({tag, "_busy"},  32'(o_busy),  32'd0);
    chk({tag, "_done"},  32'(o_done),  32'd0);
    chk({tag, "_last"},  32'(o_last),  32'd0);
    chk({tag, "_data"},  o_data,       32'd0);
    chk({tag, "_idx"},   32'(o_idx),   32'd0);
    chk({tag, "_rs1"},   32'(o_rs1),   32'd0);
    chk({tag, "_rs2"},   32'(o_rs2),   32'd0);
  endtask

  // One dump on the selected instance. rdy_mode: 0 always ready, 1 pattern
  // 1,0,0,1, 2 random. abort_idx/reset_idx interrupt while that index is shown;
  // restart_idx pulses start again once that index is pending (-1 disables).
  task automatic run_dump(input bit use_short, input int gnt_delay, input int rdy_mode,
                          input int abort_idx, input int restart_idx, input int reset_idx);
    int  first, last, head, fetch_cnt;
    bit  final_acc, restarted, rdy;
    first = use_short ? 5 : 0;
    last  = use_short ? 7 : 31;
    head = first; fetch_cnt = 0; final_acc = 0; restarted = 0;
    @(negedge clk);
    sel = use_short; start = 1'b1; gnt = 1'b0; out_ready = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      if (final_acc) begin
        chk("done_pulse", 32'(o_done),  32'd1);
        chk("done_valid", 32'(o_valid), 32'd0);
        chk("done_req",   32'(o_req),   32'd0);
        @(negedge clk);
        chk("after_done_pulse", 32'(o_done), 32'd0);
        chk("after_done_busy",  32'(o_busy), 32'd0);
        return;
      end
      chk("busy", 32'(o_busy), 32'd1);
      chk("req",  32'(o_req),  32'd1);
      chk("done_early", 32'(o_done), 32'd0);
      case (rdy_mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      if (o_valid) begin
        chk("beat_idx",  32'(o_idx),  32'(head));
        chk("beat_data", o_data,      rf_mem[head]);
        chk("beat_last", 32'(o_last), 32'(head == last));
        if (head == abort_idx) begin
          abort = 1'b1; out_ready = 1'b0;
          @(negedge clk);
          abort = 1'b0;
          chk_idle("abort");
          @(negedge clk);
          chk("abort_no_done", 32'(o_done), 32'd0);
          return;
        end
        if (head == reset_idx) begin
          rst_n = 1'b0; out_ready = 1'b0;
          @(negedge clk);
          rst_n = 1'b1;
          chk_idle("midreset");
          return;
        end
        if (rdy) begin
          if (head == last) final_acc = 1'b1;
          else head++;
        end
      end else begin
        chk("fetch_rs1", 32'(o_rs1), 32'(head));
        chk("fetch_rs2", 32'(o_rs2), 32'((head == last) ? head : head + 1));
        fetch_cnt++;
      end
      gnt = (fetch_cnt > gnt_delay);
      out_ready = rdy;
      if (head == restart_idx && !restarted) begin
        start = 1'b1;
        restarted = 1'b1;
      end
    end
    chk("timeout", 32'd0, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; gnt = 1'b1; out_ready = 1'b0; sel = 1'b0;
    for (int i = 0; i < 32; i++) rf_mem[i] = 32'hA5A5_0000 + 32'(i);
    rf_mem[0] = 32'h0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk_idle("reset_full");
    sel = 1'b1;
    #1 chk_idle("reset_short");
    sel = 1'b0;

    run_dump(1'b0, 0, 0, -1, -1, -1);   // full dump, gnt tied, always ready
    run_dump(1'b0, 5, 0, -1, -1, -1);   // grant withheld for 5 FETCH cycles
    run_dump(1'b0, 0, 1, -1, -1, -1);   // backpressure 1,0,0,1
    run_dump(1'b1, 0, 0, -1, -1, -1);   // odd-sized range 5..7
    run_dump(1'b0, 0, 0, 9, -1, -1);    // abort while idx 9 shown
    run_dump(1'b0, 0, 0, -1, -1, -1);   // restart after abort

    // abort and start together in IDLE: stays idle
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("abort_beats_start", 32'(o_busy), 32'd0);

    run_dump(1'b0, 0, 2, -1, 12, -1);   // start while busy is ignored
    run_dump(1'b0, 0, 0, -1, -1, 20);   // reset mid-dump

    for (int i = 1; i < 32; i++) rf_mem[i] = $urandom;
    for (int r = 0; r < 4; r++)
      run_dump(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 2, -1, -1, -1);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/reg_dump_reader.md
Name: reg_dump_reader

Overview:
Debug read-out engine that sits beside registerFile and walks a range of architectural registers through both asynchronous read ports. It first obtains port ownership from the core via a req/gnt handshake. It then streams each register value, with its index, on a valid/ready output channel toward the debug/UART path. It is the reader counterpart to the write-back path that fills the register file.

Parameters:
FIRST_REG, 0, first register index dumped (0..31)
LAST_REG, 31, last register index dumped (FIRST_REG <= LAST_REG <= 31)

Ports:
clk  in  1  system clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk
start  in  1  one-cycle pulse; begins a dump when idle
abort  in  1  synchronous abort; returns to IDLE from any state
rf_req  out  1  request ownership of register-file read ports
rf_gnt  in  1  core has frozen and muxed rf_rs1/rf_rs2 onto the read ports
rf_rs1  out  5  read address port 1
rf_rs2  out  5  read address port 2
rf_rd1  in  32  ReadData1 (combinational from rf_rs1)
rf_rd2  in  32  ReadData2 (combinational from rf_rs2)
out_valid  out  1  output beat valid
out_ready  in  1  consumer accepts beat
out_data  out  32  register value
out_idx  out  5  register index of out_data
out_last  out  1  beat carries LAST_REG
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse after the final beat is accepted

Behaviour:
- Reset (rst_n=0 at a rising edge): state IDLE. rf_req, out_valid, out_last, busy and done are 0. rf_rs1, rf_rs2, out_data and out_idx are 0. Internal index = FIRST_REG.
- States: IDLE, FETCH, SEND_A, SEND_B, DONE.
- IDLE: start=1 -> FETCH, index <= FIRST_REG. start is ignored in every other state.
- FETCH:
  - rf_req=1. Drive rf_rs1=index and rf_rs2=index+1; when index==LAST_REG, drive rf_rs2=index.
  - rf_gnt=0: hold in FETCH with no capture.
  - rf_gnt=1: at the edge, capture rf_rd1 into bufA and rf_rd2 into bufB, then go to SEND_A.
  - Addresses are 0 in all states other than FETCH.
- rf_req is 1 in FETCH, SEND_A and SEND_B, so the core stays frozen for the whole dump. It drops to 0 on entry to DONE or IDLE.
- SEND_A:
  - Outputs: out_valid=1, out_data=bufA, out_idx=index, out_last=(index==LAST_REG).
  - Beat accepted (out_valid & out_ready at an edge) and out_last=1 -> DONE.
  - Beat accepted and out_last=0 -> SEND_B.
- SEND_B:
  - Outputs: out_data=bufB, out_idx=index+1, out_last=(index+1==LAST_REG).
  - On accept: out_last=1 -> DONE; otherwise index <= index+2 and go to FETCH.
- Output stability: while out_valid=1 and out_ready=0, out_data, out_idx and out_last hold constant. out_valid never drops without acceptance, except on abort or reset.
- DONE: done=1 for exactly one cycle, then IDLE.
- Latency: start at edge k puts the block in FETCH from k. With gnt=1, capture happens at edge k+1 and the first out_valid appears in the cycle after it. Best-case throughput is 2 beats per 3 cycles.
- Odd range count: the final FETCH reads one register; SEND_B is skipped.
- Register x0 is dumped as whatever the file returns (0). The block does not special-case it.
- abort=1 (any state) or reset mid-dump: the next state is IDLE and all outputs return to their reset values, with no done pulse. If abort and start are both 1 in IDLE, abort wins and the block stays in IDLE.
- Index arithmetic is 6-bit internally so index+1 at 31 does not wrap; out_idx takes the low 5 bits.

Decomposition:
- Shared package rv_dbg_pkg: XLEN=32, REG_ADDR_W=5, and the dump_state_t enum (IDLE, FETCH, SEND_A, SEND_B, DONE).
- No sub-module: the FSM and the two 32-bit capture registers fit in one module.

Test Plan:
- Defaults, gnt=1 tied, out_ready=1, register file preloaded with x[i]=0xA5A50000+i:
  - start -> 32 beats, idx 0..31 with data 0x00000000 then 0xA5A50001..0xA5A5001F.
  - out_last only on idx 31; done pulses once.
  - rf_req high from FETCH entry until DONE.
- gnt withheld 5 cycles after start: rf_rs1=0 and rf_rs2=1 held, no out_valid. Release gnt -> first beat idx0 follows normally.
- Backpressure: out_ready toggles 1,0,0,1. out_data and out_idx stay stable while stalled; no beat is lost or duplicated across 32 beats.
- FIRST_REG=5, LAST_REG=7: beats idx 5,6,7. The second FETCH drives rf_rs1=rf_rs2=7. SEND_B is skipped and out_last=1 on idx 7.
- abort asserted while SEND_B shows idx 9 -> next cycle IDLE, out_valid=0, rf_req=0, no done. A new start restarts at idx 0.
- start pulsed again while busy: ignored, and the dump completes once with 32 beats. rst_n=0 mid-dump: all outputs are 0 after the edge.
